// File: rtl/gru_param_loader_pkg.sv
// Shared constants, state encoding and size helpers for the GRU parameter loader.
package gru_pkg;

    localparam logic [3:0] SEL_NONE   = 4'd0;
    localparam logic [3:0] SEL_BIAS   = 4'd1;
    localparam logic [3:0] SEL_WEIGHT = 4'd2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ_B,
        ST_LD_B,
        ST_REQ_W,
        ST_LD_W,
        ST_FIN,
        ST_SWEEP
    } state_t;

    // Number of DW_MEM-wide words holding the whole bias vector.
    function automatic int bias_words(input int och, input int dw, input int dw_mem);
        return och * dw / dw_mem;
    endfunction

    // Number of DW_MEM-wide words holding one weight row.
    function automatic int wgt_words(input int ich, input int dw, input int dw_mem);
        return ich * dw / dw_mem;
    endfunction

endpackage

// File: rtl/gru_param_loader_if.sv
// SDRAM burst-read bus plus parameter-store port, as seen by the loader.
interface gru_param_loader_if #(
    parameter int DW_MEM = 256,
    parameter int AW     = 24
);
    logic              rd_req;
    logic [AW-1:0]     rd_addr;
    logic [7:0]        rd_len;
    logic              rd_gnt;
    logic [DW_MEM-1:0] rd_data;
    logic              rd_valid;

    logic              p_en;
    logic              p_write;
    logic [3:0]        p_sel;
    logic [9:0]        p_addr;
    logic [DW_MEM-1:0] p_wdata;
    logic              w_valid;
    logic              w_last;

    modport master (
        output rd_req, rd_addr, rd_len,
        input  rd_gnt, rd_data, rd_valid,
        output p_en, p_write, p_sel, p_addr, p_wdata, w_valid, w_last
    );

    modport slave (
        input  rd_req, rd_addr, rd_len,
        output rd_gnt, rd_data, rd_valid,
        input  p_en, p_write, p_sel, p_addr, p_wdata, w_valid, w_last
    );
endinterface

// File: rtl/gru_param_loader.sv
// Loads bias then weight words from SDRAM into the GRU parameter store and
// can replay the weight words out of the store for the MAC array.
module gru_param_loader
    import gru_pkg::*;
#(
    parameter int DW             = 16,
    parameter int DW_MEM         = 256,
    parameter int INPUT_CHANNEL  = 288,
    parameter int OUTPUT_CHANNEL = 256,
    parameter int AW             = 24
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW-1:0] base_addr,
    input  logic          sweep_start,
    output logic          busy,
    output logic          loaded,
    output logic          done,
    output logic          err,
    gru_param_loader_if.master bus
);

    localparam int         BIAS_WORDS = bias_words(OUTPUT_CHANNEL, DW, DW_MEM);
    localparam int         WGT_WORDS  = wgt_words(INPUT_CHANNEL, DW, DW_MEM);
    localparam logic [9:0] BIAS_LAST  = 10'(BIAS_WORDS - 1);
    localparam logic [9:0] WGT_LAST   = 10'(WGT_WORDS - 1);

    state_t            state, state_nxt;
    logic [AW-1:0]     base;
    logic [9:0]        cnt;
    logic              beat_ok, beat_bad;

    // next values for the registered output stage
    logic              nxt_en, nxt_swp, nxt_done;
    logic [3:0]        nxt_sel;
    logic [9:0]        nxt_addr;

    logic              p_en_q, swp_q;
    logic [3:0]        p_sel_q;
    logic [9:0]        p_addr_q;
    logic [DW_MEM-1:0] p_wdata_q;
    logic              w_valid_q, w_last_q;

    // Only beats inside a load phase are accepted; the FSM leaves the phase on
    // its final beat, so anything arriving later is a protocol error.
    assign beat_ok  = bus.rd_valid && (state == ST_LD_B || state == ST_LD_W);
    assign beat_bad = bus.rd_valid && !beat_ok;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic; start has priority over sweep_start in IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (start)                     state_nxt = ST_REQ_B;
                else if (sweep_start && loaded) state_nxt = ST_SWEEP;
            end
            ST_REQ_B: if (bus.rd_gnt) state_nxt = ST_LD_B;
            ST_LD_B:  if (beat_ok && cnt == BIAS_LAST) state_nxt = ST_REQ_W;
            ST_REQ_W: if (bus.rd_gnt) state_nxt = ST_LD_W;
            ST_LD_W:  if (beat_ok && cnt == WGT_LAST) state_nxt = ST_FIN;
            ST_FIN:   state_nxt = ST_IDLE;
            ST_SWEEP: if (cnt == WGT_LAST) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Output decode feeding the registered store-port stage.
    always_comb begin
        nxt_en   = 1'b0;
        nxt_sel  = SEL_NONE;
        nxt_addr = '0;
        nxt_swp  = 1'b0;
        nxt_done = 1'b0;
        case (state)
            ST_LD_B: if (beat_ok) begin
                nxt_en   = 1'b1;
                nxt_sel  = SEL_BIAS;
                nxt_addr = cnt;
            end
            ST_LD_W: if (beat_ok) begin
                nxt_en   = 1'b1;
                nxt_sel  = SEL_WEIGHT;
                nxt_addr = cnt;
            end
            ST_SWEEP: begin
                nxt_sel  = SEL_WEIGHT;
                nxt_addr = cnt;
                nxt_swp  = 1'b1;
            end
            ST_FIN:  nxt_done = 1'b1;
            default: ;
        endcase
    end

    // Beat/address counter, latched base, sticky status bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt    <= '0;
            base   <= '0;
            loaded <= 1'b0;
            err    <= 1'b0;
        end else begin
            if (state == ST_IDLE && start) begin
                base   <= base_addr;
                loaded <= 1'b0;
            end
            if (state == ST_FIN) loaded <= 1'b1;
            if (beat_bad)        err    <= 1'b1;
            // every phase change restarts the count from word 0
            if (state != state_nxt)                cnt <= '0;
            else if (beat_ok || state == ST_SWEEP) cnt <= cnt + 10'd1;
        end
    end

    // Registered store port; w_valid/w_last trail the sweep address by the
    // store's one-cycle read latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            p_en_q    <= 1'b0;
            p_sel_q   <= SEL_NONE;
            p_addr_q  <= '0;
            p_wdata_q <= '0;
            swp_q     <= 1'b0;
            w_valid_q <= 1'b0;
            w_last_q  <= 1'b0;
            done      <= 1'b0;
        end else begin
            p_en_q    <= nxt_en;
            p_sel_q   <= nxt_sel;
            p_addr_q  <= nxt_addr;
            if (beat_ok) p_wdata_q <= bus.rd_data;
            swp_q     <= nxt_swp;
            w_valid_q <= swp_q;
            w_last_q  <= swp_q && (p_addr_q == WGT_LAST);
            done      <= nxt_done;
        end
    end

    assign busy        = (state != ST_IDLE);

    assign bus.rd_req  = (state == ST_REQ_B) || (state == ST_REQ_W);
    assign bus.rd_addr = (state == ST_REQ_B) ? base :
                         (state == ST_REQ_W) ? base + AW'(BIAS_WORDS) : '0;
    assign bus.rd_len  = (state == ST_REQ_B) ? 8'(BIAS_WORDS) :
                         (state == ST_REQ_W) ? 8'(WGT_WORDS) : 8'd0;

    assign bus.p_en    = p_en_q;
    assign bus.p_write = p_en_q;
    assign bus.p_sel   = p_sel_q;
    assign bus.p_addr  = p_addr_q;
    assign bus.p_wdata = p_wdata_q;
    assign bus.w_valid = w_valid_q;
    assign bus.w_last  = w_last_q;

endmodule

// File: tb/tb_gru_param_loader.sv
// Directed bench for gru_param_loader: table of load scenarios plus
// hand-written sweep, stray-command, reset-abort and priority sequences.
module tb_gru_param_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [23:0] base_addr;
    logic        sweep_start;
    logic        busy, loaded, done, err;

    gru_param_loader_if #(.DW_MEM(256), .AW(24)) bus ();

    gru_param_loader dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .base_addr   (base_addr),
        .sweep_start (sweep_start),
        .busy        (busy),
        .loaded      (loaded),
        .done        (done),
        .err         (err),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // store scoreboard, filled from observed write strobes
    logic [255:0] bias_mem [16];
    logic [255:0] wgt_mem  [18];
    int           wr_n, bias_n, wgt_n, req_n, done_n;
    logic [23:0]  req_a [8];
    logic [7:0]   req_l [8];

    always @(negedge clk) begin
        if (bus.p_en || bus.p_write) begin
            wr_n++;
            if (bus.p_sel == 4'd1 && bus.p_addr < 10'd16) begin
                bias_mem[bus.p_addr[3:0]] = bus.p_wdata;
                bias_n++;
            end else if (bus.p_sel == 4'd2 && bus.p_addr < 10'd18) begin
                wgt_mem[bus.p_addr[4:0]] = bus.p_wdata;
                wgt_n++;
            end
        end
        if (bus.rd_req && bus.rd_gnt) begin
            if (req_n < 8) begin
                req_a[req_n] = bus.rd_addr;
                req_l[req_n] = bus.rd_len;
            end
            req_n++;
        end
        if (done) done_n++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [255:0] beat_word(input int v);
        return {8{32'(v)}};
    endfunction

    // Grant the pending request after 3 cycles, then return n beats.
    task automatic serve_burst(input int n, input int doff, input bit gaps, input bit inj);
        int t;
        t = 0;
        while (bus.rd_req !== 1'b1 && t < 50) begin
            step();
            t++;
        end
        chk("req_seen", 256'(bus.rd_req), 256'(1));
        repeat (3) step();
        bus.rd_gnt = 1'b1;
        step();
        bus.rd_gnt = 1'b0;
        for (int k = 0; k < n; k++) begin
            if (gaps) repeat ($urandom_range(0, 2)) step();
            bus.rd_valid = 1'b1;
            bus.rd_data  = beat_word(doff + k);
            if (inj && k == 5) start = 1'b1;
            step();
            bus.rd_valid = 1'b0;
            start        = 1'b0;
        end
    endtask

    task automatic do_load(input logic [23:0] b, input bit gaps, input int doff, input bit inj);
        for (int i = 0; i < 16; i++) bias_mem[i] = '1;
        for (int i = 0; i < 18; i++) wgt_mem[i]  = '1;
        wr_n = 0; bias_n = 0; wgt_n = 0; req_n = 0; done_n = 0;
        base_addr = b;
        start     = 1'b1;
        step();
        start     = 1'b0;
        serve_burst(16, doff, gaps, 1'b0);
        serve_burst(18, doff + 16, gaps, inj);
        repeat (4) step();
    endtask

    typedef struct {
        logic [23:0] base;
        bit          gaps;
        int          doff;
        bit          inj;
        logic [23:0] exp_a0;
        logic [23:0] exp_a1;
    } vec_t;

    vec_t vecs [3];

    initial begin
        int bad_b, bad_w, e_addr, e_sel, e_wv, e_wl, e_wr;

        vecs[0] = '{base: 24'h000100, gaps: 1'b0, doff: 0,   inj: 1'b0, exp_a0: 24'h000100, exp_a1: 24'h000110};
        vecs[1] = '{base: 24'h000200, gaps: 1'b1, doff: 100, inj: 1'b1, exp_a0: 24'h000200, exp_a1: 24'h000210};
        vecs[2] = '{base: 24'hFFFFF8, gaps: 1'b1, doff: 50,  inj: 1'b0, exp_a0: 24'hFFFFF8, exp_a1: 24'h000008};

        rst = 1'b1; start = 1'b0; sweep_start = 1'b0; base_addr = '0;
        bus.rd_gnt = 1'b0; bus.rd_valid = 1'b0; bus.rd_data = '0;
        repeat (3) step();
        rst = 1'b0;

        // reset state
        chk("rst_busy", 256'(busy), 0);
        chk("rst_loaded", 256'(loaded), 0);
        chk("rst_done", 256'(done), 0);
        chk("rst_err", 256'(err), 0);
        chk("rst_rd_req", 256'(bus.rd_req), 0);
        chk("rst_p_sel", 256'(bus.p_sel), 0);
        chk("rst_w_valid", 256'(bus.w_valid), 0);

        // sweep before any load is ignored
        sweep_start = 1'b1;
        step();
        sweep_start = 1'b0;
        chk("stray_sweep_busy", 256'(busy), 0);
        step();
        chk("stray_sweep_sel", 256'(bus.p_sel), 0);

        // table of load scenarios
        for (int v = 0; v < 3; v++) begin
            do_load(vecs[v].base, vecs[v].gaps, vecs[v].doff, vecs[v].inj);
            chk($sformatf("v%0d_req_n", v), 256'(req_n), 256'(2));
            chk($sformatf("v%0d_req0_addr", v), 256'(req_a[0]), 256'(vecs[v].exp_a0));
            chk($sformatf("v%0d_req0_len", v), 256'(req_l[0]), 256'(16));
            chk($sformatf("v%0d_req1_addr", v), 256'(req_a[1]), 256'(vecs[v].exp_a1));
            chk($sformatf("v%0d_req1_len", v), 256'(req_l[1]), 256'(18));
            chk($sformatf("v%0d_writes", v), 256'(wr_n), 256'(34));
            chk($sformatf("v%0d_bias_writes", v), 256'(bias_n), 256'(16));
            chk($sformatf("v%0d_wgt_writes", v), 256'(wgt_n), 256'(18));
            bad_b = 0;
            bad_w = 0;
            for (int k = 0; k < 16; k++) if (bias_mem[k] !== beat_word(vecs[v].doff + k)) bad_b++;
            for (int k = 0; k < 18; k++) if (wgt_mem[k] !== beat_word(vecs[v].doff + 16 + k)) bad_w++;
            chk($sformatf("v%0d_bias_data_bad", v), 256'(bad_b), 0);
            chk($sformatf("v%0d_wgt_data_bad", v), 256'(bad_w), 0);
            chk($sformatf("v%0d_done_pulses", v), 256'(done_n), 256'(1));
            chk($sformatf("v%0d_loaded", v), 256'(loaded), 256'(1));
            chk($sformatf("v%0d_busy", v), 256'(busy), 0);
            chk($sformatf("v%0d_rd_req", v), 256'(bus.rd_req), 0);
            chk($sformatf("v%0d_err", v), 256'(err), 0);
        end

        // weight sweep: address k appears in cycle k, data valid one cycle later
        e_addr = 0; e_sel = 0; e_wv = 0; e_wl = 0; e_wr = 0;
        sweep_start = 1'b1;
        step();
        sweep_start = 1'b0;
        chk("sweep_busy", 256'(busy), 256'(1));
        for (int i = 0; i < 22; i++) begin
            step();
            if (i < 18) begin
                if (bus.p_sel !== 4'd2 || bus.p_addr !== 10'(i)) e_addr++;
            end else begin
                if (bus.p_sel !== 4'd0) e_sel++;
            end
            if (bus.w_valid !== (i >= 1 && i <= 18)) e_wv++;
            if (bus.w_last !== (i == 18)) e_wl++;
            if (bus.p_write !== 1'b0 || bus.p_en !== 1'b0) e_wr++;
        end
        chk("sweep_addr_bad", 256'(e_addr), 0);
        chk("sweep_sel_after_bad", 256'(e_sel), 0);
        chk("sweep_wvalid_bad", 256'(e_wv), 0);
        chk("sweep_wlast_bad", 256'(e_wl), 0);
        chk("sweep_write_bad", 256'(e_wr), 0);
        chk("sweep_idle", 256'(busy), 0);

        // stray beat in IDLE: err set, store untouched
        wr_n = 0;
        bus.rd_valid = 1'b1;
        bus.rd_data  = beat_word(999);
        step();
        bus.rd_valid = 1'b0;
        chk("idle_beat_err", 256'(err), 256'(1));
        step();
        chk("idle_beat_no_write", 256'(wr_n), 0);

        // reset at bias beat 5 aborts the load
        base_addr = 24'h000300;
        start     = 1'b1;
        step();
        start     = 1'b0;
        repeat (3) step();
        bus.rd_gnt = 1'b1;
        step();
        bus.rd_gnt = 1'b0;
        for (int k = 0; k < 5; k++) begin
            bus.rd_valid = 1'b1;
            bus.rd_data  = beat_word(k);
            step();
        end
        bus.rd_data = beat_word(5);
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.rd_valid = 1'b0;
        chk("abort_busy", 256'(busy), 0);
        chk("abort_loaded", 256'(loaded), 0);
        chk("abort_done", 256'(done), 0);
        chk("abort_err", 256'(err), 0);
        chk("abort_rd_req", 256'(bus.rd_req), 0);
        chk("abort_rd_addr", 256'(bus.rd_addr), 0);
        chk("abort_rd_len", 256'(bus.rd_len), 0);
        chk("abort_p_en", 256'(bus.p_en), 0);
        chk("abort_p_write", 256'(bus.p_write), 0);
        chk("abort_p_sel", 256'(bus.p_sel), 0);
        chk("abort_p_addr", 256'(bus.p_addr), 0);
        chk("abort_p_wdata", bus.p_wdata, 0);
        chk("abort_w_valid", 256'(bus.w_valid), 0);
        chk("abort_w_last", 256'(bus.w_last), 0);
        wr_n = 0;
        for (int k = 6; k < 16; k++) begin
            bus.rd_valid = 1'b1;
            bus.rd_data  = beat_word(k);
            step();
        end
        bus.rd_valid = 1'b0;
        repeat (2) step();
        chk("abort_late_beats_no_write", 256'(wr_n), 0);
        chk("abort_still_idle", 256'(busy), 0);

        // start beats sweep_start when both arrive with loaded set
        do_load(24'h000500, 1'b0, 7, 1'b0);
        chk("prio_loaded_before", 256'(loaded), 256'(1));
        base_addr   = 24'h000600;
        start       = 1'b1;
        sweep_start = 1'b1;
        step();
        start       = 1'b0;
        sweep_start = 1'b0;
        chk("prio_busy", 256'(busy), 256'(1));
        chk("prio_rd_req", 256'(bus.rd_req), 256'(1));
        chk("prio_rd_addr", 256'(bus.rd_addr), 256'(24'h000600));
        chk("prio_loaded_cleared", 256'(loaded), 0);
        step();
        chk("prio_no_sweep_sel", 256'(bus.p_sel), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/gru_param_loader.md
Name: gru_param_loader

Overview:
- Sequencer for the GRU parameter store: on a `start` command it fetches bias words, then weight words, as two SDRAM burst reads.
- It writes every returned 256-bit beat into the store through the store's en/write/sel/addr write port.
- After loading, it can stream all weight words back out of the store, one per cycle, for the MAC array.
- It is the only master of the store's write/sel/addr port.

Parameters:
- DW, 16, element width in bits
- DW_MEM, 256, SDRAM/store word width
- INPUT_CHANNEL, 288, weight elements per output row
- OUTPUT_CHANNEL, 256, number of bias elements
- AW, 24, SDRAM word address width

Ports:
- clk  in  1  single clock
- rst  in  1  synchronous active-high reset
- start  in  1  load command pulse, sampled in IDLE only
- base_addr  in  AW  SDRAM word address of the first bias word, sampled with start
- sweep_start  in  1  weight-stream command, sampled in IDLE only
- busy  out  1  high in every state except IDLE
- loaded  out  1  sticky; set when a load completes
- done  out  1  one-cycle pulse at load completion
- err  out  1  sticky; set by a protocol violation
- rd_req  out  1  SDRAM burst request; held until granted
- rd_addr  out  AW  burst start address
- rd_len  out  8  burst length in beats
- rd_gnt  in  1  request accepted
- rd_data  in  DW_MEM  burst beat data
- rd_valid  in  1  beat valid
- p_en, p_write  out  1 each  store write strobes
- p_sel  out  4  store select: 0 = NONE, 1 = BIAS, 2 = WEIGHT
- p_addr  out  10  store word address
- p_wdata  out  DW_MEM  store write data
- w_valid  out  1  the store's weight output is valid this cycle
- w_last  out  1  qualifies the final weight word of a sweep

Behaviour:
- Reset values:
  - All outputs 0, so p_sel = 0 (NONE).
  - State = IDLE; beat counter and address counter = 0; loaded and err cleared.
  - A reset in the middle of a load or sweep aborts it; any beats still in flight afterwards are discarded.
- Derived constants: BIAS_WORDS = OUTPUT_CHANNEL*DW/DW_MEM (16); WGT_WORDS = INPUT_CHANNEL*DW/DW_MEM (18).
- FSM states: IDLE, REQ_B, LD_B, REQ_W, LD_W, FIN, SWEEP.
- IDLE:
  - start → REQ_B; latch base_addr; clear loaded.
  - Otherwise sweep_start with loaded = 1 → SWEEP.
  - If start and sweep_start are high together, start wins.
  - sweep_start with loaded = 0 is ignored.
  - start or sweep_start outside IDLE is ignored.
- REQ_B:
  - rd_req = 1, rd_addr = base, rd_len = BIAS_WORDS.
  - On rd_gnt: drop rd_req the next cycle → LD_B.
- LD_B:
  - Each rd_valid beat k is written one cycle later: p_en = p_write = 1, p_sel = 1, p_addr = k, p_wdata = the registered rd_data.
  - After beat BIAS_WORDS-1 → REQ_W.
- REQ_W:
  - rd_addr = base + BIAS_WORDS, rd_len = WGT_WORDS; same grant handshake as REQ_B.
- LD_W:
  - Same as LD_B with p_sel = 2 and p_addr = 0..WGT_WORDS-1.
  - After the last beat → FIN.
- FIN:
  - The cycle after the last store write, done = 1 for one cycle and loaded is set → IDLE.
- Write strobes: p_en and p_write are never high outside the cycle following an accepted beat. rd_valid gaps simply stall the counter.
- SWEEP:
  - p_sel = 2, p_en = p_write = 0, p_addr = 0..WGT_WORDS-1, one address per cycle.
  - The store's read latency is 1, so w_valid is p_addr-valid delayed one cycle, and w_last accompanies address WGT_WORDS-1.
  - After the final address, p_sel returns to 0 → IDLE.
- err (sticky) is set when:
  - rd_valid arrives in IDLE, REQ_B, REQ_W, FIN or SWEEP; or
  - rd_valid arrives after the final beat of a burst.
  - The offending beat is dropped and the store is not written.
- Counters: 10-bit address counter, wraps only via explicit clear at the start of each phase. rd_addr addition is modulo 2^AW.

Decomposition:
- Shared package gru_pkg holds:
  - SEL_NONE/SEL_BIAS/SEL_WEIGHT constants;
  - the state enum;
  - the BIAS_WORDS/WGT_WORDS functions of the parameters.
- No sub-module: one FSM plus counters, with a registered output stage.

Test Plan:
- Load, base_addr = 0x000100, rd_gnt after 3 cycles, 16 + 18 contiguous beats with data = beat index:
  - Requests seen: (0x000100, 16) then (0x000110, 18).
  - Bias writes at addr 0..15 and weight writes at addr 0..17 with matching data.
  - done pulses once; loaded = 1.
- Beats with random rd_valid gaps → identical store contents; no extra p_write pulses.
- Sweep after load → p_addr 0..17 on consecutive cycles; w_valid for 18 cycles lagging by 1; w_last on the 18th; p_write never high.
- Stray commands → sweep_start before any load is ignored (busy stays 0); start during LD_W is ignored; rd_valid in IDLE sets err and no write occurs.
- rst asserted at beat 5 of LD_B → next cycle all outputs 0, state IDLE, loaded = 0; later beats set no writes.
- start and sweep_start in the same cycle with loaded = 1 → REQ_B entered; loaded cleared.
